// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit bus bridge.
//   - funct3 access size/sign codes as issued by the core
//   - FSM state encoding used by lsu_bus_bridge
//   - bus byte-enable width
package lsu_pkg;

   localparam int BE_W = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store bridge.
// Request side:  req_re/req_we/req_funct3/req_off/req_wdata in,
//                req_legal, req_be, req_wdata_rep out.
// Response side: rsp_funct3/rsp_off/rsp_rdata in, load_data out
//                (lane-selected and sign/zero-extended).
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic             req_re,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [1:0]       req_off,
   input  logic [31:0]      req_wdata,
   output logic             req_legal,
   output logic [BE_W-1:0]  req_be,
   output logic [31:0]      req_wdata_rep,
   input  logic [2:0]       rsp_funct3,
   input  logic [1:0]       rsp_off,
   input  logic [31:0]      rsp_rdata,
   output logic [31:0]      load_data
);

   logic [31:0] rsp_shifted;
   logic [7:0]  rsp_byte;
   logic [15:0] rsp_half;

   // Size/alignment legality, byte enables and store data replicated
   // across every lane so the slave can pick whichever lane it enables.
   always_comb begin
      req_legal     = 1'b0;
      req_be        = '0;
      req_wdata_rep = '0;
      case (req_funct3)
         F3_B, F3_BU: begin
            req_legal     = 1'b1;
            req_be        = 4'b0001 << req_off;
            req_wdata_rep = {4{req_wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            req_legal     = ~req_off[0];
            req_be        = 4'b0011 << req_off;
            req_wdata_rep = {2{req_wdata[15:0]}};
         end
         F3_W: begin
            req_legal     = (req_off == 2'b00);
            req_be        = 4'b1111;
            req_wdata_rep = req_wdata;
         end
         default: req_legal = 1'b0;
      endcase
      if (req_re && req_we) begin
         req_legal = 1'b0;
      end
   end

   // Load extraction: byte lane by offset, half lane by offset bit 1.
   always_comb begin
      rsp_shifted = rsp_rdata >> {rsp_off, 3'b000};
      rsp_byte    = rsp_shifted[7:0];
      rsp_half    = rsp_off[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
      case (rsp_funct3)
         F3_B:    load_data = {{24{rsp_byte[7]}}, rsp_byte};
         F3_BU:   load_data = {24'h0, rsp_byte};
         F3_H:    load_data = {{16{rsp_half[15]}}, rsp_half};
         F3_HU:   load_data = {16'h0, rsp_half};
         F3_W:    load_data = rsp_rdata;
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the single-cycle core data port and a
// request/grant/response bus.
// Core side: core_re/core_we/core_funct3/core_addr/core_wdata in,
//            core_rdata, core_stall, misaligned_fault, bus_timeout out.
// Bus side:  bus_req/bus_we/bus_addr/bus_be/bus_wdata out,
//            bus_gnt/bus_rvalid/bus_rdata in.
// Parameters: TIMEOUT_CYCLES (cycles in REQ+WAIT_RSP before abort),
//             CNT_W (timeout counter width, 2^CNT_W > TIMEOUT_CYCLES).
module lsu_bus_bridge
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             core_re,
   input  logic             core_we,
   input  logic [2:0]       core_funct3,
   input  logic [31:0]      core_addr,
   input  logic [31:0]      core_wdata,
   output logic [31:0]      core_rdata,
   output logic             core_stall,
   output logic             misaligned_fault,
   output logic             bus_timeout,
   output logic             bus_req,
   output logic             bus_we,
   output logic [31:0]      bus_addr,
   output logic [BE_W-1:0]  bus_be,
   output logic [31:0]      bus_wdata,
   input  logic             bus_gnt,
   input  logic             bus_rvalid,
   input  logic [31:0]      bus_rdata
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_e       state_q, state_d;
   logic             bus_req_q, bus_req_d;
   logic             bus_we_q, bus_we_d;
   logic [31:0]      bus_addr_q, bus_addr_d;
   logic [BE_W-1:0]  bus_be_q, bus_be_d;
   logic [31:0]      bus_wdata_q, bus_wdata_d;
   logic [31:0]      core_rdata_q, core_rdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_timeout_q, bus_timeout_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [1:0]       off_q, off_d;
   logic             is_load_q, is_load_d;

   logic             access;
   logic             req_legal;
   logic [BE_W-1:0]  req_be;
   logic [31:0]      req_wdata_rep;
   logic [31:0]      load_data;
   logic             complete;

   assign access = core_re | core_we;

   // Size and offset are captured at request time so the response is
   // decoded correctly even if the core misbehaves and drops its request.
   lsu_lane_align u_align (
      .req_re        (core_re),
      .req_we        (core_we),
      .req_funct3    (core_funct3),
      .req_off       (core_addr[1:0]),
      .req_wdata     (core_wdata),
      .req_legal     (req_legal),
      .req_be        (req_be),
      .req_wdata_rep (req_wdata_rep),
      .rsp_funct3    (funct3_q),
      .rsp_off       (off_q),
      .rsp_rdata     (bus_rdata),
      .load_data     (load_data)
   );

   // Next-state logic. core_rdata is forced to zero outside DONE so an
   // illegal load retiring straight from IDLE reads back zero.
   always_comb begin
      state_d       = state_q;
      bus_req_d     = bus_req_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_be_d      = bus_be_q;
      bus_wdata_d   = bus_wdata_q;
      core_rdata_d  = core_rdata_q;
      cnt_d         = cnt_q;
      bus_timeout_d = 1'b0;
      funct3_d      = funct3_q;
      off_d         = off_q;
      is_load_d     = is_load_q;
      complete      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            core_rdata_d = '0;
            if (access && req_legal) begin
               state_d     = ST_REQ;
               bus_req_d   = 1'b1;
               bus_we_d    = core_we;
               bus_addr_d  = {core_addr[31:2], 2'b00};
               bus_be_d    = req_be;
               bus_wdata_d = req_wdata_rep;
               cnt_d       = '0;
               funct3_d    = core_funct3;
               off_d       = core_addr[1:0];
               is_load_d   = core_re;
            end
         end
         ST_REQ, ST_WAIT_RSP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == ST_REQ) begin
               complete = bus_gnt & bus_rvalid;
               if (bus_gnt) begin
                  bus_req_d = 1'b0;
                  state_d   = ST_WAIT_RSP;
               end
            end else begin
               complete = bus_rvalid;
            end
            // A response in the last counted cycle still wins over abort.
            if (complete) begin
               state_d = ST_DONE;
               if (is_load_q) begin
                  core_rdata_d = load_data;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d       = ST_DONE;
               bus_req_d     = 1'b0;
               bus_timeout_d = 1'b1;
               core_rdata_d  = '0;
            end
         end
         ST_DONE: begin
            state_d      = ST_IDLE;
            core_rdata_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset drops any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         bus_req_q     <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_be_q      <= '0;
         bus_wdata_q   <= '0;
         core_rdata_q  <= '0;
         cnt_q         <= '0;
         bus_timeout_q <= 1'b0;
         funct3_q      <= '0;
         off_q         <= '0;
         is_load_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         bus_req_q     <= bus_req_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_be_q      <= bus_be_d;
         bus_wdata_q   <= bus_wdata_d;
         core_rdata_q  <= core_rdata_d;
         cnt_q         <= cnt_d;
         bus_timeout_q <= bus_timeout_d;
         funct3_q      <= funct3_d;
         off_q         <= off_d;
         is_load_q     <= is_load_d;
      end
   end

   // Stall and fault are combinational so they take effect in the very
   // cycle the core presents the access; both are held low during reset.
   assign core_stall       = ~rst & (((state_q == ST_IDLE) & access & req_legal)
                                     | (state_q == ST_REQ) | (state_q == ST_WAIT_RSP));
   assign misaligned_fault = ~rst & (state_q == ST_IDLE) & access & ~req_legal;

   assign core_rdata  = core_rdata_q;
   assign bus_timeout = bus_timeout_q;
   assign bus_req     = bus_req_q;
   assign bus_we      = bus_we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_be      = bus_be_q;
   assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge. A default instance carries the
// functional traffic; a second instance with TIMEOUT_CYCLES=4 shares the
// inputs and is observed only for the hung-bus case.
module tb_lsu_bus_bridge;

   localparam int BUDGET = 300;

   logic        clk;
   logic        rst;
   logic        core_re;
   logic        core_we;
   logic [2:0]  core_funct3;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   logic [31:0] m_rdata, t_rdata;
   logic        m_stall, t_stall;
   logic        m_fault, t_fault;
   logic        m_tmo, t_tmo;
   logic        m_req, t_req;
   logic        m_we, t_we;
   logic [31:0] m_addr, t_addr;
   logic [3:0]  m_be, t_be;
   logic [31:0] m_wdata, t_wdata;

   logic        sel_to;
   logic [31:0] mon_rdata, mon_addr, mon_wdata;
   logic        mon_stall, mon_fault, mon_tmo, mon_req, mon_we;
   logic [3:0]  mon_be;

   int checks;
   int errors;

   // Per-access observations filled in by applyStimulus
   logic        res_fault;
   int          res_stall;
   logic [31:0] res_addr, res_wdata, res_rdata;
   logic [3:0]  res_be;
   logic        res_we;
   logic        res_timeout, res_timeout_after, res_req_ok, res_idle_req;

   lsu_bus_bridge dut (
      .clk(clk), .rst(rst),
      .core_re(core_re), .core_we(core_we), .core_funct3(core_funct3),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(m_rdata), .core_stall(m_stall),
      .misaligned_fault(m_fault), .bus_timeout(m_tmo),
      .bus_req(m_req), .bus_we(m_we), .bus_addr(m_addr), .bus_be(m_be),
      .bus_wdata(m_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
   );

   lsu_bus_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
      .clk(clk), .rst(rst),
      .core_re(core_re), .core_we(core_we), .core_funct3(core_funct3),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(t_rdata), .core_stall(t_stall),
      .misaligned_fault(t_fault), .bus_timeout(t_tmo),
      .bus_req(t_req), .bus_we(t_we), .bus_addr(t_addr), .bus_be(t_be),
      .bus_wdata(t_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
   );

   assign mon_rdata = sel_to ? t_rdata : m_rdata;
   assign mon_stall = sel_to ? t_stall : m_stall;
   assign mon_fault = sel_to ? t_fault : m_fault;
   assign mon_tmo   = sel_to ? t_tmo   : m_tmo;
   assign mon_req   = sel_to ? t_req   : m_req;
   assign mon_we    = sel_to ? t_we    : m_we;
   assign mon_addr  = sel_to ? t_addr  : m_addr;
   assign mon_be    = sel_to ? t_be    : m_be;
   assign mon_wdata = sel_to ? t_wdata : m_wdata;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic        re;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gw;
      int          rd;
      logic        exp_fault;
      int          exp_stall;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(string n, logic re, logic we, logic [2:0] f3,
                                  logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                                  int gw, int rd, logic ef, int es, logic [31:0] ea,
                                  logic [3:0] ebe, logic [31:0] ewd, logic [31:0] erd);
      vec_t v;
      v.name = n; v.re = re; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.rdata = rdata; v.gw = gw; v.rd = rd; v.exp_fault = ef; v.exp_stall = es;
      v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd; v.exp_rdata = erd;
      return v;
   endfunction

   // Reference model: access size in bytes, offset arithmetic, per-lane replication
   function automatic void refModel(input logic re, input logic we, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] rdata, output logic legal,
                                    output logic [3:0] be, output logic [31:0] bwd,
                                    output logic [31:0] rd);
      int size;
      int off;
      logic sgn;
      logic [63:0] v;
      off = int'(addr % 4);
      legal = 1'b1;
      sgn = 1'b0;
      size = 1;
      case (f3)
         3'd0: begin size = 1; sgn = 1'b1; end
         3'd4: size = 1;
         3'd1: begin size = 2; sgn = 1'b1; end
         3'd5: size = 2;
         3'd2: size = 4;
         default: legal = 1'b0;
      endcase
      if (re && we) legal = 1'b0;
      if (off % size != 0) legal = 1'b0;
      be = '0;
      bwd = '0;
      for (int i = 0; i < 4; i++) begin
         if (i >= off && i < off + size) be[i] = 1'b1;
         bwd[i*8 +: 8] = wdata[(i % size)*8 +: 8];
      end
      rd = '0;
      if (legal && re) begin
         v = ({32'h0, rdata} >> (8*off)) & ((64'h1 << (8*size)) - 64'h1);
         if (sgn && v[8*size-1]) v = v - (64'h1 << (8*size));
         rd = v[31:0];
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one access and follow it until the core is released
   task automatic applyStimulus(input logic re, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gw, input int rd);
      int idx;
      @(negedge clk);
      core_re = re; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wdata;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = rdata;
      #1;
      res_fault = mon_fault;
      res_stall = 0;
      res_req_ok = 1'b1;
      res_addr = '0; res_be = '0; res_wdata = '0; res_we = 1'b0;
      while (mon_stall && res_stall < BUDGET) begin
         res_stall++;
         @(negedge clk);
         idx = res_stall - 1;
         bus_gnt = (idx == gw);
         bus_rvalid = (idx == gw + rd);
         #1;
         if (idx == 0) begin
            res_addr = mon_addr; res_be = mon_be; res_wdata = mon_wdata; res_we = mon_we;
         end
         if (idx <= gw && mon_stall) begin
            if (!(mon_req && mon_addr == res_addr && mon_be == res_be &&
                  mon_wdata == res_wdata && mon_we == res_we)) res_req_ok = 1'b0;
         end else if (mon_req) begin
            res_req_ok = 1'b0;
         end
      end
      res_rdata = mon_rdata;
      res_timeout = mon_tmo;
      @(negedge clk);
      core_re = 1'b0; core_we = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
      #1;
      res_timeout_after = mon_tmo;
      res_idle_req = mon_req;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic        legal;
      logic [3:0]  ebe;
      logic [31:0] ewd, erd, addr, wdata, rdata;
      logic        re, we;
      logic [2:0]  f3;
      int          gw, rd, pick;
      string       nm;

      checks = 0; errors = 0; sel_to = 1'b0;
      rst = 1'b1; core_re = 1'b0; core_we = 1'b0; core_funct3 = 3'b010;
      core_addr = '0; core_wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

      // Reset state
      #1;
      checkOutput("rst.bus_req", {31'h0, mon_req}, 32'h0);
      checkOutput("rst.bus_we", {31'h0, mon_we}, 32'h0);
      checkOutput("rst.bus_addr", mon_addr, 32'h0);
      checkOutput("rst.bus_be", {28'h0, mon_be}, 32'h0);
      checkOutput("rst.bus_wdata", mon_wdata, 32'h0);
      checkOutput("rst.core_rdata", mon_rdata, 32'h0);
      checkOutput("rst.timeout", {31'h0, mon_tmo}, 32'h0);
      checkOutput("rst.fault", {31'h0, mon_fault}, 32'h0);
      checkOutput("rst.stall", {31'h0, mon_stall}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vector table
      vecs.push_back(mkVec("sw_104", 0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0,
                           0, 2, 32'h104, 4'b1111, 32'hDEADBEEF, 32'h0));
      vecs.push_back(mkVec("sb_203", 0, 1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0, 0,
                           0, 2, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0));
      vecs.push_back(mkVec("lb_302", 1, 0, 3'b000, 32'h302, 32'h0, 32'h1280FF00, 0, 0,
                           0, 2, 32'h300, 4'b0100, 32'h0, 32'hFFFFFF80));
      vecs.push_back(mkVec("lbu_302", 1, 0, 3'b100, 32'h302, 32'h0, 32'h1280FF00, 0, 0,
                           0, 2, 32'h300, 4'b0100, 32'h0, 32'h00000080));
      vecs.push_back(mkVec("lh_302", 1, 0, 3'b001, 32'h302, 32'h0, 32'h1280FF00, 0, 0,
                           0, 2, 32'h300, 4'b1100, 32'h0, 32'h00001280));
      vecs.push_back(mkVec("lw_401", 1, 0, 3'b010, 32'h401, 32'h0, 32'h12345678, 0, 0,
                           1, 0, 32'h0, 4'h0, 32'h0, 32'h0));
      vecs.push_back(mkVec("lw_slow", 1, 0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 2, 2,
                           0, 6, 32'h400, 4'b1111, 32'h0, 32'hCAFEF00D));
      vecs.push_back(mkVec("sh_106", 0, 1, 3'b001, 32'h106, 32'h1234ABCD, 32'h0, 1, 1,
                           0, 4, 32'h104, 4'b1100, 32'hABCDABCD, 32'h0));
      vecs.push_back(mkVec("lhu_102", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 0, 3,
                           0, 5, 32'h100, 4'b1100, 32'h0, 32'h00008001));
      vecs.push_back(mkVec("lh_102", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 1, 0,
                           0, 3, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001));
      vecs.push_back(mkVec("lb_000", 1, 0, 3'b000, 32'h000, 32'h0, 32'hFFFFFF7F, 0, 0,
                           0, 2, 32'h000, 4'b0001, 32'h0, 32'h0000007F));
      vecs.push_back(mkVec("re_we", 1, 1, 3'b010, 32'h100, 32'h1, 32'h0, 0, 0,
                           1, 0, 32'h0, 4'h0, 32'h0, 32'h0));
      vecs.push_back(mkVec("f3_011", 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0,
                           1, 0, 32'h0, 4'h0, 32'h0, 32'h0));
      vecs.push_back(mkVec("sh_101", 0, 1, 3'b001, 32'h101, 32'h5555, 32'h0, 0, 0,
                           1, 0, 32'h0, 4'h0, 32'h0, 32'h0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].re, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                       vecs[i].rdata, vecs[i].gw, vecs[i].rd);
         nm = vecs[i].name;
         checkOutput({nm, ".fault"}, {31'h0, res_fault}, {31'h0, vecs[i].exp_fault});
         checkOutput({nm, ".stall_cycles"}, res_stall, vecs[i].exp_stall);
         checkOutput({nm, ".core_rdata"}, res_rdata, vecs[i].exp_rdata);
         checkOutput({nm, ".idle_bus_req"}, {31'h0, res_idle_req}, 32'h0);
         if (!vecs[i].exp_fault) begin
            checkOutput({nm, ".bus_addr"}, res_addr, vecs[i].exp_addr);
            checkOutput({nm, ".bus_be"}, {28'h0, res_be}, {28'h0, vecs[i].exp_be});
            checkOutput({nm, ".bus_we"}, {31'h0, res_we}, {31'h0, vecs[i].we});
            checkOutput({nm, ".req_hold"}, {31'h0, res_req_ok}, 32'h1);
            checkOutput({nm, ".timeout"}, {31'h0, res_timeout}, 32'h0);
            if (vecs[i].we) checkOutput({nm, ".bus_wdata"}, res_wdata, vecs[i].exp_wdata);
         end
      end

      // Hung bus on the short-timeout instance: 1 IDLE + 4 REQ stall cycles
      sel_to = 1'b1;
      pulseReset();
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h11111111, 1000, 0);
      checkOutput("tmo.stall_cycles", res_stall, 5);
      checkOutput("tmo.pulse", {31'h0, res_timeout}, 32'h1);
      checkOutput("tmo.pulse_end", {31'h0, res_timeout_after}, 32'h0);
      checkOutput("tmo.core_rdata", res_rdata, 32'h0);
      checkOutput("tmo.req_hold", {31'h0, res_req_ok}, 32'h1);
      sel_to = 1'b0;
      pulseReset();

      // Reset asserted while waiting for a response
      @(negedge clk);
      core_re = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h600;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h77777777;
      @(negedge clk);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      #1;
      checkOutput("rstwait.stall_before", {31'h0, mon_stall}, 32'h1);
      rst = 1'b1; core_re = 1'b0;
      #1;
      checkOutput("rstwait.bus_req", {31'h0, mon_req}, 32'h0);
      checkOutput("rstwait.stall", {31'h0, mon_stall}, 32'h0);
      @(negedge clk);
      rst = 1'b0; bus_rvalid = 1'b1;
      #1;
      checkOutput("rstwait.stall_after", {31'h0, mon_stall}, 32'h0);
      @(negedge clk);
      bus_rvalid = 1'b0;
      #1;
      checkOutput("rstwait.idle_stall", {31'h0, mon_stall}, 32'h0);
      checkOutput("rstwait.idle_rdata", mon_rdata, 32'h0);
      checkOutput("rstwait.idle_req", {31'h0, mon_req}, 32'h0);

      // Randomized accesses against the reference model
      for (int n = 0; n < 40; n++) begin
         pick = $urandom_range(9, 0);
         re = (pick < 5) || (pick == 9);
         we = (pick >= 5);
         pick = $urandom_range(7, 0);
         case (pick)
            0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
            4: f3 = 3'b101; 5: f3 = 3'b010; 6: f3 = 3'b000;
            default: f3 = 3'($urandom_range(7, 0));
         endcase
         addr = $urandom; wdata = $urandom; rdata = $urandom;
         gw = $urandom_range(3, 0); rd = $urandom_range(3, 0);
         refModel(re, we, f3, addr, wdata, rdata, legal, ebe, ewd, erd);
         applyStimulus(re, we, f3, addr, wdata, rdata, gw, rd);
         checkOutput("rnd.fault", {31'h0, res_fault}, {31'h0, ~legal});
         checkOutput("rnd.stall_cycles", res_stall, legal ? 2 + gw + rd : 0);
         checkOutput("rnd.core_rdata", res_rdata, erd);
         if (legal) begin
            checkOutput("rnd.bus_addr", res_addr, {addr[31:2], 2'b00});
            checkOutput("rnd.bus_be", {28'h0, res_be}, {28'h0, ebe});
            checkOutput("rnd.req_hold", {31'h0, res_req_ok}, 32'h1);
            if (we) checkOutput("rnd.bus_wdata", res_wdata, ewd);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit between the single-cycle core's data-memory port and a request/grant/response data bus.
- Converts core byte, half and word accesses into word-aligned bus transactions with byte enables, and sign/zero-extends load data.
- Stalls the core until the bus transaction completes.
- Detects misaligned or illegal accesses, and times out on a hung bus.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in REQ+WAIT_RSP before the transaction is aborted (>=1).
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- core_re  in  1  load request (level; held stable while core_stall=1)
- core_we  in  1  store request (core_re and core_we together is illegal and treated as a fault)
- core_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- core_addr  in  32  byte address
- core_wdata  in  32  store data, LSB-justified
- core_rdata  out  32  extended load data, valid in DONE
- core_stall  out  1  freeze PC/regfile write
- misaligned_fault  out  1  one-cycle pulse, access suppressed
- bus_timeout  out  1  one-cycle pulse in DONE after an abort
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  word address, bits [1:0]=0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response/ack; returned for both reads and writes
- bus_rdata  in  32  read data

Behaviour:
- Reset (async): state=IDLE. bus_req, bus_we, bus_be, bus_addr, bus_wdata, core_rdata, counter, bus_timeout and misaligned_fault all 0. Any in-flight transaction is dropped.
- States: IDLE, REQ, WAIT_RSP, DONE.
- Alignment and legality:
  - Legal: B/BU at any address; H/HU when addr[0]=0; W when addr[1:0]=0.
  - Everything else faults: other funct3 codes, and re and we together.
- IDLE, access requested and legal:
  - Register bus_addr={addr[31:2],2'b00}, bus_we, bus_be, bus_wdata.
  - Set bus_req=1, counter=0, go to REQ.
  - core_stall=1 (combinational).
- IDLE, access requested but illegal:
  - misaligned_fault=1 (combinational), core_stall=0, no bus access.
  - Loads return 0; stores are dropped. Stay in IDLE.
- Byte enables and write data:
  - bus_be: B=0001<<addr[1:0]; H=0011<<addr[1:0]; W=1111.
  - bus_wdata: B={4{wdata[7:0]}}; H={2{wdata[15:0]}}; W=wdata.
- REQ:
  - bus_req and all bus_* outputs held stable until bus_gnt.
  - On gnt: bus_req->0. If bus_rvalid is in the same cycle, go to DONE; otherwise go to WAIT_RSP.
  - core_stall=1.
- WAIT_RSP: on bus_rvalid, go to DONE; core_stall=1.
- Capturing read data: on the rvalid cycle of a load, core_rdata is registered.
  - Byte lane selected by addr[1:0]; half lane selected by addr[1].
  - B/H sign-extend, BU/HU zero-extend, W passes through.
- Timeout:
  - Counter increments each cycle in REQ or WAIT_RSP.
  - When counter reaches TIMEOUT_CYCLES-1 without completion: bus_req->0, go to DONE, core_rdata=0, bus_timeout=1 during DONE.
  - Completion takes priority over timeout in the same cycle.
- DONE:
  - core_stall=0 for exactly one cycle; the core retires the instruction at this edge.
  - Next state IDLE. The next memory instruction starts a new transaction the following cycle.
- Latency: minimum 3 cycles per memory instruction (IDLE, REQ with gnt+rvalid, DONE). Non-memory instructions see 0 added cycles.
- bus_gnt or bus_rvalid while in IDLE or DONE: ignored.
- Core request dropped mid-transaction: illegal for the core; the bridge still completes or times out, then returns to IDLE.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state encoding (IDLE, REQ, WAIT_RSP, DONE);
  - the bus byte-enable width constant.
- One combinational sub-module, lsu_lane_align, computes the legality check, bus_be, bus_wdata and load extraction/extension.
- The FSM, timeout counter and registers stay in lsu_bus_bridge.

Test Plan:
- SW addr 0x104, wdata 0xDEADBEEF, gnt+rvalid in the first REQ cycle -> bus_addr=0x104, be=1111, wdata=0xDEADBEEF, we=1; stall high for 2 cycles, low in the 3rd.
- SB addr 0x203, wdata 0x000000A5 -> bus_addr=0x200, be=1000, bus_wdata=0xA5A5A5A5.
- LB addr 0x302, bus_rdata 0x1280FF00 -> core_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LH addr 0x302 -> 0x00001280.
- LW addr 0x401 -> misaligned_fault pulse in the same cycle, bus_req never asserted, core_stall=0, core_rdata=0.
- LW, gnt delayed 3 cycles, rvalid 2 cycles after gnt -> bus_req stable through the wait, stall high for 6 cycles, data captured on rvalid.
- Bus never grants with TIMEOUT_CYCLES=4 -> DONE after 4 cycles in REQ, bus_timeout pulse, core_rdata=0. Separately, asserting rst in WAIT_RSP -> bus_req=0 and state IDLE immediately.
